// File: rtl/serial_to_parallel_if.sv
// Stream-side and word-side signals of the serial-to-parallel reassembler.
// PARITY_CHECK_EN adds the parity_err output.
interface serial_to_parallel_if #(
    parameter int WIDTH = 4
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             serial_in;
    logic             valid_in;
    logic             empty_in;
    logic             out_ready;
    logic [WIDTH-1:0] parallel_out;
    logic             out_valid;
    logic             overrun;
    logic             abort;
    logic [CW-1:0]    bit_count;
`ifdef PARITY_CHECK_EN
    logic             parity_err;
`endif

    modport master (
        output serial_in, valid_in, empty_in, out_ready,
        input  parallel_out, out_valid, overrun, abort, bit_count
`ifdef PARITY_CHECK_EN
        , input parity_err
`endif
    );

    modport slave (
        input  serial_in, valid_in, empty_in, out_ready,
        output parallel_out, out_valid, overrun, abort, bit_count
`ifdef PARITY_CHECK_EN
        , output parity_err
`endif
    );
endinterface

// File: rtl/serial_to_parallel.sv
// Reassembles qualified serial bits (LSB first) into WIDTH-bit words with
// valid/ready hand-off, sticky overrun and abort pulse. PARITY_CHECK_EN adds an even-parity bit.
module serial_to_parallel #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_to_parallel_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
`ifdef PARITY_CHECK_EN
    localparam int LAST = WIDTH;
`else
    localparam int LAST = WIDTH - 1;
`endif

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             abort_q, abort_d;
    logic [WIDTH-1:0] word;
    logic             complete;
`ifdef PARITY_CHECK_EN
    logic             perr_q, perr_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            pout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            abort_q <= 1'b0;
`ifdef PARITY_CHECK_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            pout_q  <= pout_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            abort_q <= abort_d;
`ifdef PARITY_CHECK_EN
            perr_q  <= perr_d;
`endif
        end
    end

    always_comb begin
        // Shift register with the current bit merged in; the parity bit has no slot.
        word = shreg_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (cnt_q == CW'(i)) word[i] = bus.serial_in;
        end
        complete = bus.valid_in && (cnt_q == CW'(LAST));

        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        pout_d  = pout_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        abort_d = 1'b0;
`ifdef PARITY_CHECK_EN
        perr_d  = perr_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.valid_in) begin
                    state_d = SHIFT;
                    cnt_d   = CW'(1);
                    shreg_d = word;
                end
            end
            SHIFT: begin
                if (bus.valid_in) begin
                    if (complete) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        shreg_d = '0;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        shreg_d = word;
                    end
                end else if (bus.empty_in) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    shreg_d = '0;
                    abort_d = 1'b1;
                end
            end
        endcase

        if (complete) begin
            if (!valid_q || bus.out_ready) begin
                pout_d  = word;
                valid_d = 1'b1;
`ifdef PARITY_CHECK_EN
                perr_d  = (^word) ^ bus.serial_in;
`endif
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    assign bus.parallel_out = pout_q;
    assign bus.out_valid    = valid_q;
    assign bus.overrun      = ovr_q;
    assign bus.abort        = abort_q;
    assign bus.bit_count    = cnt_q;
`ifdef PARITY_CHECK_EN
    assign bus.parity_err   = perr_q;
`endif
endmodule

// File: doc/serial_to_parallel.md
Name: serial_to_parallel

Overview:
Downstream neighbour of the 4-bit parallel-to-serial converter. Consumes that stage's serial_out, valid_out and empty_out streams. Reassembles qualified serial bits, LSB first, into WIDTH-bit words and presents each word on a valid/ready output interface, with overrun and abort reporting.

Parameters:
WIDTH, 4, bits per reassembled word; legal range 2..16.

Ports:
clk  input  1  single clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
serial_in  input  1  serial data bit; connects to upstream serial_out.
valid_in  input  1  qualifies serial_in this cycle; connects to upstream valid_out.
empty_in  input  1  upstream has no data; connects to upstream empty_out.
out_ready  input  1  downstream accepts parallel_out when out_valid=1.
parallel_out  output  WIDTH  assembled word; bit 0 is the first bit received.
out_valid  output  1  parallel_out holds an unconsumed word.
overrun  output  1  sticky; a completed word was dropped.
abort  output  1  one-cycle pulse; a partial word was discarded.
bit_count  output  clog2(WIDTH+1)  number of bits collected toward the current word.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - parallel_out=0, out_valid=0, overrun=0, abort=0, bit_count=0.
  - Shift register cleared; FSM returns to IDLE.
- FSM states:
  - IDLE: bit_count=0. A valid_in=1 edge samples the bit, moves to SHIFT, sets bit_count=1.
  - SHIFT: each valid_in=1 edge stores serial_in at position bit_count and increments bit_count. When valid_in=0, state and count hold; gaps of any length are legal.
  - Word completion: the edge that samples bit WIDTH-1 completes the word. The FSM returns to IDLE with bit_count=0.
- Word hand-off, on the completing edge:
  - If out_valid=0, or out_valid=1 with out_ready=1: parallel_out loads the new word and out_valid=1. The word is visible one cycle after the last bit's edge.
  - If out_valid=1 with out_ready=0: the new word is dropped, parallel_out is unchanged, and overrun is set.
- Output handshake:
  - An out_valid=1 and out_ready=1 edge with no word completing clears out_valid.
  - parallel_out holds its value while out_valid=1 and out_ready=0.
  - parallel_out retains its last value after consumption.
- Abort:
  - Triggered on an edge with empty_in=1, valid_in=0 and state SHIFT.
  - The partial word is discarded, bit_count returns to 0, the FSM goes to IDLE, and abort pulses high for exactly one cycle.
  - empty_in=1 in IDLE has no effect.
  - valid_in=1 together with empty_in=1 means the bit is sampled normally and no abort occurs.
- overrun clears only on rst.
- Reset mid-word or with out_valid=1: all state is lost, with no abort pulse and no overrun.
- With WIDTH=4, a continuous valid_in stream produces one word every 4 cycles.

Optional Feature:
PARITY_CHECK_EN
- When defined:
  - Each frame is WIDTH data bits followed by one even-parity bit, so the word completes on bit index WIDTH.
  - Adds output parity_err (1 bit). On the completing edge it is set to 1 if the XOR of the data bits and the parity bit is 1, else 0. It updates only when parallel_out loads, and its reset value is 0.
  - The word is still delivered when parity fails.
  - bit_count counts up to WIDTH.
  - Abort and overrun rules are unchanged; a dropped word does not update parity_err.
- When undefined:
  - No parity bit and no parity_err port; behaviour is exactly as above.

Test Plan:
1. WIDTH=4, rst high 2 cycles then low; drive bits 0,0,1,0 with valid_in=1 for 4 consecutive cycles, out_ready=1 -> parallel_out=4'h4 and out_valid=1 one cycle after the 4th edge, then out_valid=0 on the next edge.
2. Bits 1,0 then valid_in=0 for 3 cycles then bits 1,0 -> bit_count holds at 2 during the gap; parallel_out=4'h5.
3. out_ready=0; send words 4'h4 then 4'h5 back-to-back -> parallel_out stays 4'h4, out_valid=1, overrun=1; raise out_ready -> out_valid clears and overrun stays 1.
4. Send bits 1,1, then empty_in=1 with valid_in=0 for one cycle -> abort high exactly one cycle, bit_count=0; next 4 bits 1,0,1,0 -> parallel_out=4'h5.
5. Assert rst asynchronously mid-word with out_valid=1 -> all outputs 0 immediately, before the next clk edge; a subsequent full word is received correctly.
6. PARITY_CHECK_EN defined: data 4'h5 with parity 0 -> parity_err=0; data 4'h4 with parity 0 -> parity_err=1, and parallel_out=4'h4 is still delivered.
